// File: rtl/snake_head_motion_if.sv
// snake_head_motion_if: velocity/frame inputs and head position outputs of the snake head mover.
interface snake_head_motion_if;
    logic signed [31:0] x_velocity;
    logic signed [31:0] y_velocity;
    logic               frame_tick;
    logic               restart;
    logic [9:0]         head_x;
    logic [9:0]         head_y;
    logic               step_done;
    logic               wall_hit;
    logic               overrun;
    modport master (
        output x_velocity, y_velocity, frame_tick, restart,
        input  head_x, head_y, step_done, wall_hit, overrun
    );
    modport slave (
        input  x_velocity, y_velocity, frame_tick, restart,
        output head_x, head_y, step_done, wall_hit, overrun
    );
endinterface

// File: rtl/snake_head_motion.sv
// snake_head_motion: steps the snake head by saturated velocity once per frame group, with reversal block and clamp/wrap edges.
module snake_head_motion #(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int MAX_SPEED   = 8,
    parameter int STEP_FRAMES = 1,
    parameter bit WRAP        = 1'b0
) (
    input logic              clk,
    input logic              reset_n,
    snake_head_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LATCH, MOVE, COMMIT} state_t;
    state_t             state;
    logic [3:0]         div;
    logic               pending;
    logic signed [4:0]  vx, vy, hx, hy, cvx, cvy;
    logic signed [10:0] sx, sy;
    logic [9:0]         nx, ny, ax, ay;
    logic               req, rev, x_out, y_out;

    function automatic logic signed [4:0] sat(input logic signed [31:0] v);
        return v > MAX_SPEED ? 5'(MAX_SPEED) : v < -MAX_SPEED ? 5'(-MAX_SPEED) : v[4:0];
    endfunction

    // One correction is enough since MAX_SPEED is smaller than the playfield span.
    function automatic logic [9:0] edge_fix(input logic signed [10:0] s, input int lo, input int hi);
        logic signed [10:0] r;
        r = s < lo ? (WRAP ? s + 11'(hi - lo + 1) : 11'(lo)) :
            s > hi ? (WRAP ? s - 11'(hi - lo + 1) : 11'(hi)) : s;
        return r[9:0];
    endfunction

    always_comb begin
        req   = bus.frame_tick && div == 4'(STEP_FRAMES - 1);
        cvx   = sat(bus.x_velocity);
        cvy   = sat(bus.y_velocity);
        rev   = (cvx != 0 || cvy != 0) && cvx == -hx && cvy == -hy && (hx != 0 || hy != 0);
        sx    = $signed({1'b0, bus.head_x}) + $signed({{6{vx[4]}}, vx});
        sy    = $signed({1'b0, bus.head_y}) + $signed({{6{vy[4]}}, vy});
        x_out = sx < X_MIN || sx > X_MAX;
        y_out = sy < Y_MIN || sy > Y_MAX;
        ax    = edge_fix(sx, X_MIN, X_MAX);
        ay    = edge_fix(sy, Y_MIN, Y_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            div           <= 4'd0;
            pending       <= 1'b0;
            {vx, vy, hx, hy} <= '0;
            nx            <= 10'(X_INIT);
            ny            <= 10'(Y_INIT);
            bus.head_x    <= 10'(X_INIT);
            bus.head_y    <= 10'(Y_INIT);
            bus.step_done <= 1'b0;
            bus.wall_hit  <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (bus.restart) begin
            state         <= IDLE;
            div           <= 4'd0;
            pending       <= 1'b0;
            {vx, vy, hx, hy} <= '0;
            nx            <= 10'(X_INIT);
            ny            <= 10'(Y_INIT);
            bus.head_x    <= 10'(X_INIT);
            bus.head_y    <= 10'(Y_INIT);
            bus.step_done <= 1'b0;
            bus.wall_hit  <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.step_done <= 1'b0;
            if (bus.frame_tick) div <= req ? 4'd0 : div + 4'd1;
            if (req && pending) bus.overrun <= 1'b1;
            case (state)
                IDLE: if (req) state <= LATCH;
                LATCH: begin
                    pending <= pending | req;
                    vx      <= rev ? hx : cvx;
                    vy      <= rev ? hy : cvy;
                    if (!rev && (cvx != 0 || cvy != 0)) begin
                        hx <= cvx;
                        hy <= cvy;
                    end
                    state <= MOVE;
                end
                MOVE: begin
                    pending <= pending | req;
                    nx      <= ax;
                    ny      <= ay;
                    if (!WRAP && (x_out || y_out)) bus.wall_hit <= 1'b1;
                    state <= COMMIT;
                end
                // A request landing in COMMIT starts the next step directly.
                COMMIT: begin
                    bus.head_x    <= nx;
                    bus.head_y    <= ny;
                    bus.step_done <= 1'b1;
                    pending       <= 1'b0;
                    state         <= (pending || req) ? LATCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
